mmio_axi_bridge: RTL and testbench

Single-outstanding AXI4 master that turns the core's simple MMIO load/store handshake into single-beat, 64-bit, INCR AXI transactions. It sits between the LSU's uncached/MMIO path and the peripheral bus, directly feeding the CLINT and any other AXI slave on that bus. Every access is one 8-byte beat (len 0, size 3'b011, burst INCR), which is the exact shape the CLINT accepts. Responses return to the core with read data and an error flag.

---
 rtl/mmio_axi_bridge_pkg.sv | 20 ++
 rtl/mmio_axi_bridge.sv | 239 +++++++++++++++++++++++
 tb/tb_mmio_axi_bridge.sv | 444 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mmio_axi_bridge_pkg.sv
// Shared AXI constants and FSM states for the MMIO-to-AXI bridge.
// Every access is a single 8-byte INCR beat.
package mmio_axi_bridge_pkg;

    localparam logic [2:0] AXI_SIZE_8B    = 3'b011;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
    localparam logic [3:0] AXI_CACHE_MMIO = 4'b0010;
    localparam logic [3:0] MMIO_AXI_ID    = 4'd1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR,
        ST_BW,
        ST_RD,
        ST_RW,
        ST_RESP
    } state_t;

endpackage

// File: rtl/mmio_axi_bridge.sv
// Single-outstanding AXI4 master: one core MMIO request becomes one
// 64-bit single-beat AXI transaction; all outputs are registered.
module mmio_axi_bridge
    import mmio_axi_bridge_pkg::*;
#(
    parameter logic [3:0] AXI_ID = MMIO_AXI_ID
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    input  logic [7:0]  req_wstrb,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [63:0] resp_rdata,
    output logic        resp_err,
    output logic [3:0]  axi_aw_id,
    output logic [63:0] axi_aw_addr,
    output logic [7:0]  axi_aw_len,
    output logic [2:0]  axi_aw_size,
    output logic [1:0]  axi_aw_burst,
    output logic [3:0]  axi_aw_cache,
    output logic [2:0]  axi_aw_prot,
    output logic [3:0]  axi_aw_qos,
    output logic        axi_aw_valid,
    input  logic        axi_aw_ready,
    output logic [63:0] axi_w_data,
    output logic [7:0]  axi_w_strb,
    output logic        axi_w_last,
    output logic        axi_w_valid,
    input  logic        axi_w_ready,
    input  logic [3:0]  axi_b_id,
    input  logic [1:0]  axi_b_resp,
    input  logic        axi_b_valid,
    output logic        axi_b_ready,
    output logic [3:0]  axi_ar_id,
    output logic [63:0] axi_ar_addr,
    output logic [7:0]  axi_ar_len,
    output logic [2:0]  axi_ar_size,
    output logic [1:0]  axi_ar_burst,
    output logic [3:0]  axi_ar_cache,
    output logic [2:0]  axi_ar_prot,
    output logic [3:0]  axi_ar_qos,
    output logic        axi_ar_valid,
    input  logic        axi_ar_ready,
    input  logic [3:0]  axi_r_id,
    input  logic [63:0] axi_r_data,
    input  logic [1:0]  axi_r_resp,
    input  logic        axi_r_last,
    input  logic        axi_r_valid,
    output logic        axi_r_ready
);

    state_t      state_q, state_d;
    logic [63:0] addr_q, addr_d;
    logic [63:0] wdata_q, wdata_d;
    logic [7:0]  wstrb_q, wstrb_d;
    logic [63:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic        req_rdy_q, req_rdy_d;
    logic        rsp_vld_q, rsp_vld_d;
    logic        aw_vld_q, aw_vld_d;
    logic        w_vld_q, w_vld_d;
    logic        ar_vld_q, ar_vld_d;
    logic        b_rdy_q, b_rdy_d;
    logic        r_rdy_q, r_rdy_d;
    logic        aw_done_q, aw_done_d;
    logic        w_done_q, w_done_d;
    logic        aw_hs, w_hs;
    logic        unused_ids;

    assign unused_ids = ^{axi_b_id, axi_r_id};

    assign aw_hs = aw_vld_q & axi_aw_ready;
    assign w_hs  = w_vld_q & axi_w_ready;

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        req_rdy_d = req_rdy_q;
        rsp_vld_d = rsp_vld_q;
        aw_vld_d  = aw_vld_q;
        w_vld_d   = w_vld_q;
        ar_vld_d  = ar_vld_q;
        b_rdy_d   = b_rdy_q;
        r_rdy_d   = r_rdy_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        unique case (state_q)
            ST_IDLE: begin
                req_rdy_d = 1'b1;
                if (req_valid && req_rdy_q) begin
                    req_rdy_d = 1'b0;
                    addr_d    = req_addr;
                    wdata_d   = req_wdata;
                    wstrb_d   = req_wstrb;
                    if (req_addr[2:0] != 3'b000) begin
                        rsp_vld_d = 1'b1;
                        err_d     = 1'b1;
                        rdata_d   = '0;
                        state_d   = ST_RESP;
                    end else if (req_we) begin
                        aw_vld_d  = 1'b1;
                        w_vld_d   = 1'b1;
                        aw_done_d = 1'b0;
                        w_done_d  = 1'b0;
                        state_d   = ST_WR;
                    end else begin
                        ar_vld_d = 1'b1;
                        state_d  = ST_RD;
                    end
                end
            end
            ST_WR: begin
                if (aw_hs) begin
                    aw_vld_d  = 1'b0;
                    aw_done_d = 1'b1;
                end
                if (w_hs) begin
                    w_vld_d  = 1'b0;
                    w_done_d = 1'b1;
                end
                if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
                    b_rdy_d = 1'b1;
                    state_d = ST_BW;
                end
            end
            ST_BW: begin
                if (b_rdy_q && axi_b_valid) begin
                    b_rdy_d   = 1'b0;
                    rsp_vld_d = 1'b1;
                    rdata_d   = '0;
                    err_d     = (axi_b_resp != AXI_RESP_OKAY);
                    state_d   = ST_RESP;
                end
            end
            ST_RD: begin
                if (ar_vld_q && axi_ar_ready) begin
                    ar_vld_d = 1'b0;
                    r_rdy_d  = 1'b1;
                    state_d  = ST_RW;
                end
            end
            ST_RW: begin
                if (r_rdy_q && axi_r_valid) begin
                    r_rdy_d   = 1'b0;
                    rsp_vld_d = 1'b1;
                    err_d     = (axi_r_resp != AXI_RESP_OKAY) || !axi_r_last;
                    rdata_d   = err_d ? 64'd0 : axi_r_data;
                    state_d   = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_vld_q && resp_ready) begin
                    rsp_vld_d = 1'b0;
                    req_rdy_d = 1'b1;
                    state_d   = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
            req_rdy_q <= 1'b0;
            rsp_vld_q <= 1'b0;
            aw_vld_q  <= 1'b0;
            w_vld_q   <= 1'b0;
            ar_vld_q  <= 1'b0;
            b_rdy_q   <= 1'b0;
            r_rdy_q   <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
            req_rdy_q <= req_rdy_d;
            rsp_vld_q <= rsp_vld_d;
            aw_vld_q  <= aw_vld_d;
            w_vld_q   <= w_vld_d;
            ar_vld_q  <= ar_vld_d;
            b_rdy_q   <= b_rdy_d;
            r_rdy_q   <= r_rdy_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
        end
    end

    assign req_ready    = req_rdy_q;
    assign resp_valid   = rsp_vld_q;
    assign resp_rdata   = rdata_q;
    assign resp_err     = err_q;

    assign axi_aw_id    = AXI_ID;
    assign axi_aw_addr  = addr_q;
    assign axi_aw_len   = 8'd0;
    assign axi_aw_size  = AXI_SIZE_8B;
    assign axi_aw_burst = AXI_BURST_INCR;
    assign axi_aw_cache = AXI_CACHE_MMIO;
    assign axi_aw_prot  = 3'b000;
    assign axi_aw_qos   = 4'd0;
    assign axi_aw_valid = aw_vld_q;

    assign axi_w_data   = wdata_q;
    assign axi_w_strb   = wstrb_q;
    assign axi_w_last   = 1'b1;
    assign axi_w_valid  = w_vld_q;
    assign axi_b_ready  = b_rdy_q;

    assign axi_ar_id    = AXI_ID;
    assign axi_ar_addr  = addr_q;
    assign axi_ar_len   = 8'd0;
    assign axi_ar_size  = AXI_SIZE_8B;
    assign axi_ar_burst = AXI_BURST_INCR;
    assign axi_ar_cache = AXI_CACHE_MMIO;
    assign axi_ar_prot  = 3'b000;
    assign axi_ar_qos   = 4'd0;
    assign axi_ar_valid = ar_vld_q;
    assign axi_r_ready  = r_rdy_q;

endmodule

// File: tb/tb_mmio_axi_bridge.sv
// Bench for mmio_axi_bridge: AXI stub slave with a CLINT-style mtime,
// plus a byte-level memory model for expected load data.
module tb_mmio_axi_bridge;

    localparam logic [63:0] MTIME_ADDR    = 64'h0000_0000_0200_BFF8;
    localparam logic [63:0] MTIMECMP_ADDR = 64'h0000_0000_0200_4000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0, req_ready, req_we = 1'b0;
    logic [63:0] req_addr = '0, req_wdata = '0;
    logic [7:0]  req_wstrb = '0;
    logic        resp_valid, resp_ready = 1'b0, resp_err;
    logic [63:0] resp_rdata;
    logic [3:0]  aw_id, ar_id, aw_cache, ar_cache, aw_qos, ar_qos;
    logic [63:0] aw_addr, ar_addr, w_data;
    logic [7:0]  aw_len, ar_len, w_strb;
    logic [2:0]  aw_size, ar_size, aw_prot, ar_prot;
    logic [1:0]  aw_burst, ar_burst;
    logic        aw_valid, aw_ready, w_last, w_valid, w_ready;
    logic        ar_valid, ar_ready;
    logic [1:0]  b_resp = '0, r_resp = '0;
    logic        b_valid = 1'b0, b_ready;
    logic [63:0] r_data = '0;
    logic        r_last = 1'b0, r_valid = 1'b0, r_ready;

    always #5 clk = ~clk;

    mmio_axi_bridge dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err),
        .axi_aw_id(aw_id), .axi_aw_addr(aw_addr), .axi_aw_len(aw_len),
        .axi_aw_size(aw_size), .axi_aw_burst(aw_burst),
        .axi_aw_cache(aw_cache), .axi_aw_prot(aw_prot),
        .axi_aw_qos(aw_qos), .axi_aw_valid(aw_valid),
        .axi_aw_ready(aw_ready),
        .axi_w_data(w_data), .axi_w_strb(w_strb), .axi_w_last(w_last),
        .axi_w_valid(w_valid), .axi_w_ready(w_ready),
        .axi_b_id(4'd1), .axi_b_resp(b_resp), .axi_b_valid(b_valid),
        .axi_b_ready(b_ready),
        .axi_ar_id(ar_id), .axi_ar_addr(ar_addr), .axi_ar_len(ar_len),
        .axi_ar_size(ar_size), .axi_ar_burst(ar_burst),
        .axi_ar_cache(ar_cache), .axi_ar_prot(ar_prot),
        .axi_ar_qos(ar_qos), .axi_ar_valid(ar_valid),
        .axi_ar_ready(ar_ready),
        .axi_r_id(4'd1), .axi_r_data(r_data), .axi_r_resp(r_resp),
        .axi_r_last(r_last), .axi_r_valid(r_valid), .axi_r_ready(r_ready)
    );

    // ---------------- stub slave ----------------
    int          cfg_aw_delay = 0, cfg_w_delay = 0, cfg_ar_delay = 0;
    logic        cfg_b_block = 1'b0, cfg_r_last = 1'b1;
    logic [1:0]  cfg_b_resp = 2'b00, cfg_r_resp = 2'b00;
    int          aw_wait = 0, w_wait = 0, ar_wait = 0;
    logic        aw_got = 1'b0, w_got = 1'b0;
    logic [63:0] aw_addr_q = '0, w_data_q = '0;
    logic [7:0]  w_strb_q = '0;
    logic [63:0] mtime = 64'd500, mtime_at_ar = '0;
    logic [63:0] slave_mem [logic [63:0]];
    int          aw_cnt = 0, w_cnt = 0, b_cnt = 0, ar_cnt = 0;
    int          any_valid_cnt = 0;
    logic [7:0]  cap_len = '1;
    logic [2:0]  cap_size = '0;
    logic [1:0]  cap_burst = '0;
    logic [3:0]  cap_id = '0, cap_cache = '0;
    logic        cap_last = 1'b0;

    assign aw_ready = aw_valid && (aw_wait >= cfg_aw_delay);
    assign w_ready  = w_valid && (w_wait >= cfg_w_delay);
    assign ar_ready = ar_valid && (ar_wait >= cfg_ar_delay);

    always @(posedge clk) begin
        logic        ag, wg;
        logic [63:0] a, d, m;
        logic [7:0]  s;
        mtime <= mtime + 64'd1;
        if (rst) begin
            aw_wait <= 0; w_wait <= 0; ar_wait <= 0;
            aw_got <= 1'b0; w_got <= 1'b0;
            b_valid <= 1'b0; r_valid <= 1'b0;
        end else begin
            if (aw_valid || w_valid || ar_valid) any_valid_cnt <= any_valid_cnt + 1;
            aw_wait <= (aw_valid && !aw_ready) ? aw_wait + 1 : 0;
            w_wait  <= (w_valid && !w_ready) ? w_wait + 1 : 0;
            ar_wait <= (ar_valid && !ar_ready) ? ar_wait + 1 : 0;
            ag = aw_got || (aw_valid && aw_ready);
            wg = w_got || (w_valid && w_ready);
            a = aw_got ? aw_addr_q : aw_addr;
            d = w_got ? w_data_q : w_data;
            s = w_got ? w_strb_q : w_strb;
            if (aw_valid && aw_ready) begin
                aw_cnt <= aw_cnt + 1; aw_got <= 1'b1; aw_addr_q <= aw_addr;
                cap_len <= aw_len; cap_size <= aw_size; cap_burst <= aw_burst;
                cap_id <= aw_id; cap_cache <= aw_cache;
            end
            if (w_valid && w_ready) begin
                w_cnt <= w_cnt + 1; w_got <= 1'b1;
                w_data_q <= w_data; w_strb_q <= w_strb; cap_last <= w_last;
            end
            if (ag && wg && !b_valid && !cfg_b_block) begin
                m = slave_mem.exists(a) ? slave_mem[a] : 64'd0;
                for (int i = 0; i < 8; i++)
                    if (s[i]) m[8*i +: 8] = d[8*i +: 8];
                slave_mem[a] = m;
                aw_got <= 1'b0; w_got <= 1'b0;
                b_valid <= 1'b1; b_resp <= cfg_b_resp;
            end
            if (b_valid && b_ready) begin
                b_valid <= 1'b0; b_cnt <= b_cnt + 1;
            end
            if (ar_valid && ar_ready) begin
                ar_cnt <= ar_cnt + 1;
                mtime_at_ar <= mtime;
                if (ar_addr == MTIME_ADDR) r_data <= mtime;
                else r_data <= slave_mem.exists(ar_addr) ? slave_mem[ar_addr] : 64'd0;
                r_resp <= cfg_r_resp; r_last <= cfg_r_last; r_valid <= 1'b1;
            end
            if (r_valid && r_ready) r_valid <= 1'b0;
        end
    end

    // ---------------- stability monitor ----------------
    int          stab_viol = 0;
    logic        p_aw_v = 0, p_aw_r = 0, p_w_v = 0, p_w_r = 0;
    logic        p_ar_v = 0, p_ar_r = 0, p_rs_v = 0, p_rs_r = 0, p_rst = 1;
    logic [63:0] p_aw_a = 0, p_w_d = 0, p_ar_a = 0, p_rs_d = 0;
    logic        p_rs_e = 0;

    always @(posedge clk) begin
        if (!rst && !p_rst) begin
            if (p_aw_v && !p_aw_r && (!aw_valid || aw_addr != p_aw_a)) stab_viol <= stab_viol + 1;
            if (p_w_v && !p_w_r && (!w_valid || w_data != p_w_d)) stab_viol <= stab_viol + 1;
            if (p_ar_v && !p_ar_r && (!ar_valid || ar_addr != p_ar_a)) stab_viol <= stab_viol + 1;
            if (p_rs_v && !p_rs_r && (!resp_valid || resp_rdata != p_rs_d || resp_err != p_rs_e))
                stab_viol <= stab_viol + 1;
        end
        p_rst <= rst;
        p_aw_v <= aw_valid; p_aw_r <= aw_ready; p_aw_a <= aw_addr;
        p_w_v <= w_valid; p_w_r <= w_ready; p_w_d <= w_data;
        p_ar_v <= ar_valid; p_ar_r <= ar_ready; p_ar_a <= ar_addr;
        p_rs_v <= resp_valid; p_rs_r <= resp_ready;
        p_rs_d <= resp_rdata; p_rs_e <= resp_err;
    end

    // ---------------- reference model ----------------
    logic [63:0] model_mem [logic [63:0]];
    int errors = 0, checks = 0;

    function automatic logic [63:0] model_rd(input logic [63:0] a);
        return model_mem.exists(a) ? model_mem[a] : 64'd0;
    endfunction

    task automatic model_wr(input logic [63:0] a, input logic [63:0] d, input logic [7:0] s);
        logic [63:0] m;
        m = model_rd(a);
        for (int i = 0; i < 8; i++)
            if (s[i]) m[8*i +: 8] = d[8*i +: 8];
        model_mem[a] = m;
    endtask

    // Issues one request; lat = cycles from accept edge to resp_valid, -1 on timeout.
    task automatic start_req(input logic we, input logic [63:0] a, input logic [63:0] d,
                             input logic [7:0] s, input int max_lat, output int lat,
                             output logic [63:0] rd, output logic er);
        int n;
        lat = -1; rd = '0; er = 1'b0;
        @(negedge clk);
        n = 0;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) return;
        req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d; req_wstrb = s;
        @(posedge clk);
        #1 req_valid = 1'b0;
        for (int c = 1; c <= max_lat; c++) begin
            if (resp_valid) begin
                lat = c; rd = resp_rdata; er = resp_err;
                return;
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic finish_resp();
        resp_ready = 1'b1;
        @(posedge clk);
        #1 resp_ready = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({aw_valid, w_valid, ar_valid, b_ready, r_ready, resp_valid, req_ready} !== 7'b0) begin
            errors++;
            $display("FAIL reset_handshakes got=%b want=0",
                     {aw_valid, w_valid, ar_valid, b_ready, r_ready, resp_valid, req_ready});
        end
        checks++;
        if (resp_rdata !== 64'd0 || resp_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_resp got=%h/%b want=0/0", resp_rdata, resp_err);
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_req_ready got=%b want=1", req_ready);
        end
    endtask

    task automatic test_clint();
        int lat; logic [63:0] rd; logic er; int b0;
        b0 = b_cnt;
        start_req(1'b1, MTIMECMP_ADDR, 64'h1000, 8'hFF, 20, lat, rd, er);
        model_wr(MTIMECMP_ADDR, 64'h1000, 8'hFF);
        checks++;
        if (lat !== 3 || er !== 1'b0) begin
            errors++;
            $display("FAIL clint_store lat=%0d err=%b want lat=3 err=0", lat, er);
        end
        finish_resp();
        checks++;
        if ({cap_len, cap_size, cap_burst, cap_id, cap_cache, cap_last} !==
            {8'd0, 3'd3, 2'd1, 4'd1, 4'b0010, 1'b1} || b_cnt - b0 != 1) begin
            errors++;
            $display("FAIL clint_aw_fields len=%0d size=%0d burst=%0d id=%0d cache=%0d last=%b b=%0d",
                     cap_len, cap_size, cap_burst, cap_id, cap_cache, cap_last, b_cnt - b0);
        end
        start_req(1'b0, MTIME_ADDR, '0, '0, 20, lat, rd, er);
        checks++;
        if (lat !== 3 || er !== 1'b0 || rd !== mtime_at_ar) begin
            errors++;
            $display("FAIL clint_mtime lat=%0d err=%b rdata=%h want 3/0/%h", lat, er, rd, mtime_at_ar);
        end
        finish_resp();
    endtask

    task automatic test_random_rw();
        int lat; logic [63:0] a, d, rd; logic [7:0] s; logic er;
        for (int i = 0; i < 12; i++) begin
            a = 64'h2000_0000 + 64'($urandom_range(0, 7)) * 8;
            d = {$urandom, $urandom};
            s = 8'($urandom);
            cfg_aw_delay = $urandom_range(0, 2);
            cfg_w_delay = $urandom_range(0, 2);
            cfg_ar_delay = $urandom_range(0, 2);
            start_req(1'b1, a, d, s, 30, lat, rd, er);
            model_wr(a, d, s);
            checks++;
            if (lat < 3 || er !== 1'b0 || rd !== 64'd0) begin
                errors++;
                $display("FAIL rand_store[%0d] lat=%0d err=%b rdata=%h", i, lat, er, rd);
            end
            finish_resp();
            start_req(1'b0, a, '0, '0, 30, lat, rd, er);
            checks++;
            if (lat !== 3 + cfg_ar_delay || er !== 1'b0 || rd !== model_rd(a)) begin
                errors++;
                $display("FAIL rand_load[%0d] lat=%0d err=%b rdata=%h want %0d/0/%h",
                         i, lat, er, rd, 3 + cfg_ar_delay, model_rd(a));
            end
            finish_resp();
        end
        cfg_aw_delay = 0; cfg_w_delay = 0; cfg_ar_delay = 0;
    endtask

    task automatic test_aw_before_w();
        int lat, aw0, w0, b0, held; logic [63:0] rd; logic er;
        aw0 = aw_cnt; w0 = w_cnt; b0 = b_cnt;
        cfg_w_delay = 2;
        fork
            start_req(1'b1, 64'h2000_0100, 64'hCAFE_F00D_1234_5678, 8'hFF, 20, lat, rd, er);
            begin
                held = 0;
                repeat (4) begin
                    @(posedge clk);
                    #2;
                    if (w_valid && !aw_valid) held++;
                end
            end
        join
        model_wr(64'h2000_0100, 64'hCAFE_F00D_1234_5678, 8'hFF);
        checks++;
        if (lat !== 5 || er !== 1'b0) begin
            errors++;
            $display("FAIL aw_first_resp lat=%0d err=%b want 5/0", lat, er);
        end
        checks++;
        if (held !== 2 || aw_cnt - aw0 != 1 || w_cnt - w0 != 1 || b_cnt - b0 != 1) begin
            errors++;
            $display("FAIL aw_first_channels held=%0d aw=%0d w=%0d b=%0d want 2/1/1/1",
                     held, aw_cnt - aw0, w_cnt - w0, b_cnt - b0);
        end
        finish_resp();
        cfg_w_delay = 0;
    endtask

    task automatic test_misaligned();
        int lat, v0; logic [63:0] rd; logic er; logic [63:0] a;
        for (int i = 0; i < 4; i++) begin
            v0 = any_valid_cnt;
            a = (i == 0) ? 64'h2000_0004 : 64'h2000_0000 + 64'($urandom_range(1, 7));
            start_req(i[0], a, 64'hFFFF, 8'hFF, 10, lat, rd, er);
            repeat (2) @(posedge clk);
            #1;
            checks++;
            if (lat !== 1 || er !== 1'b1 || rd !== 64'd0 || any_valid_cnt != v0) begin
                errors++;
                $display("FAIL misaligned[%0d] lat=%0d err=%b rdata=%h axi_valids=%0d",
                         i, lat, er, rd, any_valid_cnt - v0);
            end
            finish_resp();
        end
    endtask

    task automatic test_read_errors();
        int lat; logic [63:0] rd; logic er; logic bad;
        model_wr(64'h2000_0200, 64'h1111_2222_3333_4444, 8'hFF);
        start_req(1'b1, 64'h2000_0200, 64'h1111_2222_3333_4444, 8'hFF, 20, lat, rd, er);
        finish_resp();
        cfg_r_resp = 2'b10;
        start_req(1'b0, 64'h2000_0200, '0, '0, 20, lat, rd, er);
        checks++;
        if (lat !== 3 || er !== 1'b1 || rd !== 64'd0) begin
            errors++;
            $display("FAIL rresp_err lat=%0d err=%b rdata=%h want 3/1/0", lat, er, rd);
        end
        finish_resp();
        cfg_r_resp = 2'b00; cfg_r_last = 1'b0;
        start_req(1'b0, 64'h2000_0200, '0, '0, 20, lat, rd, er);
        checks++;
        if (lat !== 3 || er !== 1'b1 || rd !== 64'd0) begin
            errors++;
            $display("FAIL rlast_err lat=%0d err=%b rdata=%h want 3/1/0", lat, er, rd);
        end
        bad = 1'b0;
        repeat (5) begin
            @(posedge clk);
            #1;
            if (!resp_valid || resp_err !== er || resp_rdata !== rd || req_ready) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL resp_hold got v=%b err=%b req_ready=%b want 1/%b/0",
                     resp_valid, resp_err, req_ready, er);
        end
        finish_resp();
        cfg_r_last = 1'b1;
        cfg_b_resp = 2'b11;
        start_req(1'b1, 64'h2000_0208, 64'h5, 8'h01, 20, lat, rd, er);
        model_wr(64'h2000_0208, 64'h5, 8'h01);
        checks++;
        if (lat !== 3 || er !== 1'b1) begin
            errors++;
            $display("FAIL bresp_err lat=%0d err=%b want 3/1", lat, er);
        end
        finish_resp();
        cfg_b_resp = 2'b00;
    endtask

    task automatic test_back_to_back();
        int lat; logic [63:0] rd; logic er;
        start_req(1'b0, 64'h2000_0200, '0, '0, 20, lat, rd, er);
        finish_resp();
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_req_ready got=%b want=1", req_ready);
        end
        checks++;
        if (rd !== model_rd(64'h2000_0200) || er !== 1'b0) begin
            errors++;
            $display("FAIL b2b_load rdata=%h err=%b want %h/0", rd, er, model_rd(64'h2000_0200));
        end
    endtask

    task automatic test_reset_mid();
        int lat; logic [63:0] rd; logic er;
        cfg_b_block = 1'b1;
        start_req(1'b1, 64'h2000_0300, 64'hDEAD, 8'hFF, 4, lat, rd, er);
        checks++;
        if (lat !== -1 || b_ready !== 1'b1) begin
            errors++;
            $display("FAIL mid_reach_bw lat=%0d b_ready=%b want -1/1", lat, b_ready);
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if ({aw_valid, w_valid, ar_valid, b_ready, r_ready, resp_valid, req_ready} !== 7'b0) begin
            errors++;
            $display("FAIL mid_reset got=%b want=0",
                     {aw_valid, w_valid, ar_valid, b_ready, r_ready, resp_valid, req_ready});
        end
        rst = 1'b0;
        cfg_b_block = 1'b0;
        start_req(1'b1, 64'h2000_0300, 64'hBEEF, 8'hFF, 20, lat, rd, er);
        model_wr(64'h2000_0300, 64'hBEEF, 8'hFF);
        finish_resp();
        start_req(1'b0, 64'h2000_0300, '0, '0, 20, lat, rd, er);
        checks++;
        if (lat !== 3 || er !== 1'b0 || rd !== model_rd(64'h2000_0300)) begin
            errors++;
            $display("FAIL mid_recover lat=%0d err=%b rdata=%h want 3/0/%h",
                     lat, er, rd, model_rd(64'h2000_0300));
        end
        finish_resp();
    endtask

    task automatic test_stability();
        checks++;
        if (stab_viol != 0) begin
            errors++;
            $display("FAIL stability violations=%0d want 0", stab_viol);
        end
    endtask

    initial begin
        test_reset();
        test_clint();
        test_random_rw();
        test_aw_before_w();
        test_misaligned();
        test_read_errors();
        test_back_to_back();
        test_reset_mid();
        test_stability();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
